instruction_prefetcher: RTL and testbench
=========================================

INSTRUCTION_PREFETCHER -- requirements
Module: instruction_prefetcher

Interface
REQ-001 Parameter ADDR_WIDTH, 32, width of all PC/address ports.
REQ-002 Parameter INST_WIDTH, 32, instruction word width.
REQ-003 Parameter QUEUE_DEPTH, 4, fetch-queue entries; power of two, >=2.
REQ-004 Parameter PREDICT_EN, 1, 1 enables static branch/JAL prediction; 0 always predicts PC+4.
REQ-005 Parameter RESET_PC, 0, PC loaded on reset.
REQ-006 clk_in  input  1  single clock; all state updates on rising edge.
REQ-007 rst_in  input  1  reset; asynchronous, active-high.
REQ-008 rdy_in  input  1  global enable; low freezes all state.
REQ-009 if_to_ic_addr  output  ADDR_WIDTH  icache lookup address (= PC).
REQ-010 ic_to_if_hit / ic_to_if_hit_inst  input  1 / INST_WIDTH  combinational hit and word for if_to_ic_addr.
REQ-011 if_to_ic_ready / if_to_ic_inst_addr / if_to_ic_inst  output  1 / ADDR_WIDTH / INST_WIDTH  one-cycle icache fill pulse.
REQ-012 if_to_mc_ready / if_to_mc_PC  output  1 / ADDR_WIDTH  memory fetch request, held until response.
REQ-013 mc_to_if_ready / mc_to_if_inst  input  1 / INST_WIDTH  one-cycle memory response.
REQ-014 if_to_dc_ready  output  1  queue head valid.
REQ-015 dc_to_if_accept  input  1  decoder consumes head this cycle.
REQ-016 if_to_dc_inst / if_to_dc_PC / if_to_dc_pred_taken  output  INST_WIDTH / ADDR_WIDTH / 1  head entry fields.
REQ-017 alter_valid / alterPC  input  1 / ADDR_WIDTH  mispredict redirect.

Function
REQ-018 FSM states: IDLE, WAIT_MEM, DISCARD.
REQ-019 IDLE, queue not full, hit: enqueue {hit_inst, PC, pred} that cycle; PC <= next PC.
REQ-020 IDLE, queue not full, miss: assert if_to_mc_ready with if_to_mc_PC=PC; go WAIT_MEM.
REQ-021 WAIT_MEM, mc_to_if_ready: enqueue response, pulse if_to_ic_ready with {PC, inst}, PC <= next PC, go IDLE.
REQ-022 Queue full: no lookup enqueue, no new memory request; enqueue is blocked even if a dequeue occurs the same cycle.
REQ-023 Dequeue when if_to_dc_ready && dc_to_if_accept; entries leave in fetch order.
REQ-024 Next PC: PREDICT_EN=1 and opcode 1101111 (JAL) -> PC + sext(J-imm, 21 bit); opcode 1100011 with inst[31]=1 -> PC + sext(B-imm, 13 bit), pred_taken=1; otherwise PC+4, pred_taken=0.
REQ-025 Address arithmetic modulo 2^ADDR_WIDTH; wrap at top of address space is silent.
REQ-026 alter_valid (priority over all other events): queue emptied, PC <= alterPC, same-cycle enqueue/dequeue suppressed.
REQ-027 alter_valid in WAIT_MEM without same-cycle response -> DISCARD, request dropped; with same-cycle response -> response dropped, IDLE.
REQ-028 DISCARD: next mc_to_if_ready dropped (no enqueue, no icache fill), then IDLE; a further alter_valid in DISCARD only updates PC.
REQ-029 rdy_in low: no state, PC, queue or FSM change; outputs hold.

Reset
REQ-030 Asynchronous reset: PC=RESET_PC, FSM=IDLE, queue empty, pointers 0.
REQ-031 Reset values: all ready/valid outputs 0, if_to_dc_pred_taken 0, all data/address outputs 0.
REQ-032 Reset mid-WAIT_MEM abandons the request; the stale response after reset is ignored (mc_to_if_ready with FSM=IDLE has no effect).

Structure
REQ-033 Opcode constants (JAL, BRANCH), FSM state encoding and RESET_PC default belong in the shared defines package.
REQ-034 Queue implemented as sub-module fetch_queue (parametrised FIFO, QUEUE_DEPTH x {inst, PC, pred}, flush input).

Verification
REQ-035 Reset, all icache hits, accept=1: PC 0,4,8,C on successive cycles; if_to_dc_ready from cycle 1.
REQ-036 Miss at 0x10: if_to_mc_ready=1, PC=0x10; response 0x00000013 after 3 cycles -> enqueued, icache fill pulse {0x10, 0x00000013}.
REQ-037 Hit inst 0xFE000EE3 (BEQ, offset -4) at 0x20: pred_taken=1, next fetch 0x1C; PREDICT_EN=0: next 0x24, pred_taken=0.
REQ-038 accept=0, QUEUE_DEPTH=4: after 4 enqueues no further request; one accept -> one more enqueue next cycle.
REQ-039 alter_valid=1, alterPC=0x100 in WAIT_MEM: queue empty next cycle; next response dropped; next request to 0x100.
REQ-040 rdy_in low 5 cycles mid-stream, then reset asserted asynchronously: state frozen, then all outputs 0 without clock edge.

Source files
------------

// File: rtl/instruction_prefetcher_pkg.sv
// Shared constants for the instruction prefetcher: RISC-V opcodes used for
// static prediction, the fetch FSM encoding and the default reset PC.
package instruction_prefetcher_pkg;

  localparam logic [6:0]  OPC_JAL          = 7'b1101111;
  localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
  localparam logic [31:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    DISCARD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue of {inst, PC, pred_taken} entries with a flush input.
// Head fields read as zero while the queue is empty.
module fetch_queue #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq,
  input  logic [INST_WIDTH-1:0] enq_inst,
  input  logic [ADDR_WIDTH-1:0] enq_pc,
  input  logic                  enq_pred,
  input  logic                  deq,
  input  logic                  flush,
  output logic                  full,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] head_inst,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic                  head_pred
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic                  pred_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (!enq && deq) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr] <= enq_inst;
      pc_mem[wr_ptr]   <= enq_pc;
      pred_mem[wr_ptr] <= enq_pred;
    end
  end

  always_comb begin
    valid     = (count != '0);
    full      = (count == (PTR_W + 1)'(DEPTH));
    head_inst = valid ? inst_mem[rd_ptr] : '0;
    head_pc   = valid ? pc_mem[rd_ptr]   : '0;
    head_pred = valid ? pred_mem[rd_ptr] : 1'b0;
  end

endmodule

// File: rtl/instruction_prefetcher.sv
// Instruction fetch front end: icache lookup, memory fill on miss, static
// branch/JAL prediction and an in-order queue feeding the decoder.
module instruction_prefetcher
  import instruction_prefetcher_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INST_WIDTH  = 32,
  parameter int unsigned           QUEUE_DEPTH = 4,
  parameter bit                    PREDICT_EN  = 1'b1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic [ADDR_WIDTH-1:0] if_to_ic_addr,
  input  logic                  ic_to_if_hit,
  input  logic [INST_WIDTH-1:0] ic_to_if_hit_inst,
  output logic                  if_to_ic_ready,
  output logic [ADDR_WIDTH-1:0] if_to_ic_inst_addr,
  output logic [INST_WIDTH-1:0] if_to_ic_inst,
  output logic                  if_to_mc_ready,
  output logic [ADDR_WIDTH-1:0] if_to_mc_PC,
  input  logic                  mc_to_if_ready,
  input  logic [INST_WIDTH-1:0] mc_to_if_inst,
  output logic                  if_to_dc_ready,
  input  logic                  dc_to_if_accept,
  output logic [INST_WIDTH-1:0] if_to_dc_inst,
  output logic [ADDR_WIDTH-1:0] if_to_dc_PC,
  output logic                  if_to_dc_pred_taken,
  input  logic                  alter_valid,
  input  logic [ADDR_WIDTH-1:0] alterPC
);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [INST_WIDTH-1:0] fetch_inst;
  logic [20:0]           j_imm;
  logic [12:0]           b_imm;
  logic                  pred_taken;
  logic                  q_full;
  logic                  enq;
  logic                  deq;
  logic                  flush;

  assign if_to_ic_addr = pc;

  // The word being enqueued this cycle also drives the next-PC prediction.
  always_comb begin
    fetch_inst = (state == WAIT_MEM) ? mc_to_if_inst : ic_to_if_hit_inst;
    j_imm      = {fetch_inst[31], fetch_inst[19:12], fetch_inst[20], fetch_inst[30:21], 1'b0};
    b_imm      = {fetch_inst[31], fetch_inst[7], fetch_inst[30:25], fetch_inst[11:8], 1'b0};
    next_pc    = pc + ADDR_WIDTH'(4);
    pred_taken = 1'b0;
    if (PREDICT_EN) begin
      if (fetch_inst[6:0] == OPC_JAL) begin
        next_pc    = pc + ADDR_WIDTH'($signed(j_imm));
        pred_taken = 1'b1;
      end else if (fetch_inst[6:0] == OPC_BRANCH && fetch_inst[31]) begin
        next_pc    = pc + ADDR_WIDTH'($signed(b_imm));
        pred_taken = 1'b1;
      end
    end
    enq   = rdy_in && !alter_valid &&
            ((state == IDLE && !q_full && ic_to_if_hit) ||
             (state == WAIT_MEM && mc_to_if_ready));
    deq   = rdy_in && !alter_valid && if_to_dc_ready && dc_to_if_accept;
    flush = rdy_in && alter_valid;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state              <= IDLE;
      pc                 <= RESET_PC;
      if_to_ic_ready     <= 1'b0;
      if_to_ic_inst_addr <= '0;
      if_to_ic_inst      <= '0;
      if_to_mc_ready     <= 1'b0;
      if_to_mc_PC        <= '0;
    end else if (rdy_in) begin
      if_to_ic_ready <= 1'b0;
      if (alter_valid) begin
        // Redirect: any in-flight response is dropped, either now or in DISCARD.
        pc             <= alterPC;
        if_to_mc_ready <= 1'b0;
        if (state == WAIT_MEM)
          state <= mc_to_if_ready ? IDLE : DISCARD;
        else if (state == DISCARD && mc_to_if_ready)
          state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (!q_full) begin
              if (ic_to_if_hit) begin
                pc <= next_pc;
              end else begin
                if_to_mc_ready <= 1'b1;
                if_to_mc_PC    <= pc;
                state          <= WAIT_MEM;
              end
            end
          end
          WAIT_MEM: begin
            if (mc_to_if_ready) begin
              pc                 <= next_pc;
              if_to_mc_ready     <= 1'b0;
              if_to_ic_ready     <= 1'b1;
              if_to_ic_inst_addr <= pc;
              if_to_ic_inst      <= mc_to_if_inst;
              state              <= IDLE;
            end
          end
          DISCARD: begin
            if (mc_to_if_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  fetch_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH),
    .DEPTH      (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk_in),
    .rst       (rst_in),
    .enq       (enq),
    .enq_inst  (fetch_inst),
    .enq_pc    (pc),
    .enq_pred  (pred_taken),
    .deq       (deq),
    .flush     (flush),
    .full      (q_full),
    .valid     (if_to_dc_ready),
    .head_inst (if_to_dc_inst),
    .head_pc   (if_to_dc_PC),
    .head_pred (if_to_dc_pred_taken)
  );

endmodule

// File: tb/tb_instruction_prefetcher.sv
// Directed bench for instruction_prefetcher: icache model, hand-driven memory
// responses, scoreboard of expected queue entries popped as the decoder accepts.
module tb_instruction_prefetcher;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
  } entry_t;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic [31:0] if_to_ic_addr;
  logic        ic_to_if_hit;
  logic [31:0] ic_to_if_hit_inst;
  logic        if_to_ic_ready;
  logic [31:0] if_to_ic_inst_addr, if_to_ic_inst;
  logic        if_to_mc_ready;
  logic [31:0] if_to_mc_PC;
  logic        mc_to_if_ready;
  logic [31:0] mc_to_if_inst;
  logic        if_to_dc_ready, dc_to_if_accept;
  logic [31:0] if_to_dc_inst, if_to_dc_PC;
  logic        if_to_dc_pred_taken;
  logic        alter_valid;
  logic [31:0] alterPC;

  logic        np_ic_ready, np_mc_ready, np_dc_ready, np_pred;
  logic [31:0] np_ic_addr, np_ic_inst_addr, np_ic_inst, np_mc_pc, np_dc_inst, np_dc_pc;

  logic        hit_en;
  logic [31:0] miss_lo, miss_hi;
  entry_t      sb[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h20) return 32'hFE000EE3;
    return {a[11:0], 20'h00013};
  endfunction

  always_comb begin
    ic_to_if_hit      = hit_en && !(if_to_ic_addr >= miss_lo && if_to_ic_addr < miss_hi);
    ic_to_if_hit_inst = imem(if_to_ic_addr);
  end

  instruction_prefetcher u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_to_ic_addr(if_to_ic_addr), .ic_to_if_hit(ic_to_if_hit), .ic_to_if_hit_inst(ic_to_if_hit_inst),
    .if_to_ic_ready(if_to_ic_ready), .if_to_ic_inst_addr(if_to_ic_inst_addr), .if_to_ic_inst(if_to_ic_inst),
    .if_to_mc_ready(if_to_mc_ready), .if_to_mc_PC(if_to_mc_PC),
    .mc_to_if_ready(mc_to_if_ready), .mc_to_if_inst(mc_to_if_inst),
    .if_to_dc_ready(if_to_dc_ready), .dc_to_if_accept(dc_to_if_accept),
    .if_to_dc_inst(if_to_dc_inst), .if_to_dc_PC(if_to_dc_PC), .if_to_dc_pred_taken(if_to_dc_pred_taken),
    .alter_valid(alter_valid), .alterPC(alterPC)
  );

  instruction_prefetcher #(.PREDICT_EN(1'b0), .RESET_PC(32'h20)) u_np (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(1'b1),
    .if_to_ic_addr(np_ic_addr), .ic_to_if_hit(1'b1), .ic_to_if_hit_inst(32'hFE000EE3),
    .if_to_ic_ready(np_ic_ready), .if_to_ic_inst_addr(np_ic_inst_addr), .if_to_ic_inst(np_ic_inst),
    .if_to_mc_ready(np_mc_ready), .if_to_mc_PC(np_mc_pc),
    .mc_to_if_ready(1'b0), .mc_to_if_inst(32'h0),
    .if_to_dc_ready(np_dc_ready), .dc_to_if_accept(1'b1),
    .if_to_dc_inst(np_dc_inst), .if_to_dc_PC(np_dc_pc), .if_to_dc_pred_taken(np_pred),
    .alter_valid(1'b0), .alterPC(32'h0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc, input logic pred);
    entry_t e;
    e.inst = inst;
    e.pc   = pc;
    e.pred = pred;
    sb.push_back(e);
  endtask

  // Called at negedge+1 with inputs set; pops the head the DUT will hand over
  // at the coming posedge, then advances to the next negedge+1.
  task automatic cycle();
    entry_t e;
    #1;
    if (rdy_in && !rst_in) begin
      if (alter_valid) begin
        sb.delete();
      end else if (if_to_dc_ready && dc_to_if_accept) begin
        if (sb.size() == 0) begin
          chk("unexpected_head", if_to_dc_ready, 0);
        end else begin
          e = sb.pop_front();
          chk("head_inst", if_to_dc_inst, e.inst);
          chk("head_pc", if_to_dc_PC, e.pc);
          chk("head_pred", if_to_dc_pred_taken, e.pred);
        end
      end
    end
    @(posedge clk_in);
    @(negedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; hit_en = 1'b0; miss_lo = 32'h10; miss_hi = 32'h14;
    dc_to_if_accept = 1'b0; alter_valid = 1'b0; alterPC = '0;
    mc_to_if_ready = 1'b0; mc_to_if_inst = '0;
    @(negedge clk_in); #1;

    chk("rst_ic_addr", if_to_ic_addr, 0);
    chk("rst_mc_ready", if_to_mc_ready, 0);
    chk("rst_mc_pc", if_to_mc_PC, 0);
    chk("rst_ic_ready", if_to_ic_ready, 0);
    chk("rst_ic_fill", {if_to_ic_inst_addr, if_to_ic_inst}, 0);
    chk("rst_dc_ready", if_to_dc_ready, 0);
    chk("rst_dc_fields", {if_to_dc_inst, if_to_dc_PC, 31'd0, if_to_dc_pred_taken}, 0);

    // Sequential hits from reset, decoder always accepting.
    rst_in = 1'b0; hit_en = 1'b1; dc_to_if_accept = 1'b1;
    for (int i = 0; i < 4; i++) push(imem(32'(i * 4)), 32'(i * 4), 1'b0);
    chk("np_reset_pc", np_ic_addr, 32'h20);
    cycle();
    chk("seq_pc1", if_to_ic_addr, 32'h4);
    chk("seq_ready1", if_to_dc_ready, 1);
    chk("np_next_pc", np_ic_addr, 32'h24);
    chk("np_head_pc", np_dc_pc, 32'h20);
    chk("np_head_pred", np_pred, 0);
    cycle();
    chk("seq_pc2", if_to_ic_addr, 32'h8);
    chk("np_next_pc2", np_ic_addr, 32'h28);
    cycle();
    chk("seq_pc3", if_to_ic_addr, 32'hC);
    cycle();
    chk("seq_pc4", if_to_ic_addr, 32'h10);
    cycle();

    // Miss at 0x10, response three cycles later.
    chk("miss_req", if_to_mc_ready, 1);
    chk("miss_req_pc", if_to_mc_PC, 32'h10);
    push(32'h00000013, 32'h10, 1'b0);
    cycle();
    chk("miss_hold1", if_to_mc_ready, 1);
    cycle();
    chk("miss_hold2", if_to_mc_ready, 1);
    mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00000013;
    cycle();
    mc_to_if_ready = 1'b0; hit_en = 1'b0;
    chk("fill_pulse", if_to_ic_ready, 1);
    chk("fill_addr", if_to_ic_inst_addr, 32'h10);
    chk("fill_inst", if_to_ic_inst, 32'h00000013);
    chk("miss_req_drop", if_to_mc_ready, 0);
    chk("after_fill_pc", if_to_ic_addr, 32'h14);
    cycle();

    // Redirect while waiting: request dropped, next response discarded.
    chk("fill_once", if_to_ic_ready, 0);
    chk("miss2_req_pc", if_to_mc_PC, 32'h14);
    alter_valid = 1'b1; alterPC = 32'h100;
    cycle();
    alter_valid = 1'b0;
    chk("alter_pc", if_to_ic_addr, 32'h100);
    chk("alter_req_drop", if_to_mc_ready, 0);
    chk("alter_empty", if_to_dc_ready, 0);
    mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h12345013;
    cycle();
    mc_to_if_ready = 1'b0;
    chk("discard_no_fill", if_to_ic_ready, 0);
    chk("discard_no_enq", if_to_dc_ready, 0);
    cycle();
    chk("redir_req", if_to_mc_ready, 1);
    chk("redir_req_pc", if_to_mc_PC, 32'h100);

    // JAL +0x20 from memory.
    push(32'h0200006F, 32'h100, 1'b1);
    mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h0200006F;
    cycle();
    mc_to_if_ready = 1'b0;
    chk("jal_target", if_to_ic_addr, 32'h120);
    chk("jal_fill_inst", if_to_ic_inst, 32'h0200006F);
    cycle();
    chk("miss3_req_pc", if_to_mc_PC, 32'h120);

    // Redirect coinciding with the response: response dropped, back to IDLE.
    alter_valid = 1'b1; alterPC = 32'h20; mc_to_if_ready = 1'b1; mc_to_if_inst = 32'h00000013;
    cycle();
    alter_valid = 1'b0; mc_to_if_ready = 1'b0;
    chk("alter_resp_no_fill", if_to_ic_ready, 0);
    chk("alter_resp_no_enq", if_to_dc_ready, 0);
    chk("alter_resp_no_req", if_to_mc_ready, 0);

    // Backward branch at 0x20 loops with 0x1C; decoder stalled fills the queue.
    hit_en = 1'b1; miss_lo = '0; miss_hi = '0; dc_to_if_accept = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] p;
      p = (i % 2 == 0) ? 32'h20 : 32'h1C;
      chk("loop_pc", if_to_ic_addr, p);
      push(imem(p), p, i % 2 == 0);
      cycle();
    end
    hit_en = 1'b0;
    chk("full_pc", if_to_ic_addr, 32'h20);
    cycle();
    chk("full_no_req", if_to_mc_ready, 0);
    chk("full_pc_hold", if_to_ic_addr, 32'h20);
    hit_en = 1'b1; dc_to_if_accept = 1'b1;
    cycle();
    dc_to_if_accept = 1'b0;
    chk("full_deq_blocks_enq", if_to_ic_addr, 32'h20);
    chk("full_new_head", if_to_dc_PC, 32'h1C);
    push(32'hFE000EE3, 32'h20, 1'b1);
    cycle();
    chk("refill_pc", if_to_ic_addr, 32'h1C);

    // Freeze with rdy low, including an ignored redirect.
    rdy_in = 1'b0; dc_to_if_accept = 1'b1; alter_valid = 1'b1; alterPC = 32'h300;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("freeze_pc", if_to_ic_addr, 32'h1C);
      chk("freeze_head", if_to_dc_PC, 32'h1C);
      chk("freeze_ready", if_to_dc_ready, 1);
    end
    alter_valid = 1'b0;
    #1 rst_in = 1'b1;
    #1;
    chk("arst_ic_addr", if_to_ic_addr, 0);
    chk("arst_dc_ready", if_to_dc_ready, 0);
    chk("arst_dc_fields", {if_to_dc_inst, if_to_dc_PC, 31'd0, if_to_dc_pred_taken}, 0);
    chk("arst_mc", {if_to_mc_PC, 31'd0, if_to_mc_ready}, 0);
    sb.delete();

    // Silent wrap at the top of the address space.
    @(negedge clk_in); #1;
    rst_in = 1'b0; rdy_in = 1'b1; alter_valid = 1'b1; alterPC = 32'hFFFF_FFFC;
    hit_en = 1'b1; dc_to_if_accept = 1'b0;
    cycle();
    alter_valid = 1'b0;
    chk("wrap_start", if_to_ic_addr, 32'hFFFF_FFFC);
    push(imem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1'b0);
    cycle();
    chk("wrap_pc", if_to_ic_addr, 0);
    hit_en = 1'b0; dc_to_if_accept = 1'b1;
    cycle();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
